prbs7_chk_32b: RTL and testbench
================================

// Module: prbs7_chk_32b
// PURPOSE
//  Receive-side checker for the 32-bit PRBS7 test pattern (recurrence s[k+7] = s[k]^s[k+1], bit 31 = oldest).
//  Self-synchronising: locks onto incoming words with no seed exchange, counts bit errors and received words for BER.
//  Sits after the deserialiser / DMRO capture, opposite the 32-bit PRBS7 generator.
// PARAMETERS
//  LOCK_WORDS    8   consecutive clean checked words required to enter LOCKED
//  UNLOCK_WORDS  4   consecutive errored words in LOCKED that force UNLOCKED
//  CNT_W         16  width of errCnt and wordCnt (saturating)
// PORTS
//  CLK          in   1      clock
//  RSTn         in   1      asynchronous active-low reset
//  dataIn       in   32     received word, bit 31 oldest
//  dataInValid  in   1      dataIn qualifier; words with valid=0 are ignored entirely
//  clrErr       in   1      synchronous clear of errCnt/wordCnt
//  locked       out  1      checker in LOCKED state
//  errFlag      out  1      1-cycle pulse: last checked word had >=1 mismatch
//  errCnt       out  CNT_W  accumulated mismatch bits while LOCKED, saturating
//  wordCnt      out  CNT_W  words checked while LOCKED, saturating
// BEHAVIOUR
//  - Reset: locked=0, errFlag=0, errCnt=0, wordCnt=0, hist=0, histValid=0, state UNLOCKED, streak counters 0.
//  - Extended vector x[38:0] = {hist[6:0], dataIn}; mismatch m[i] = x[i]^x[i+6]^x[i+7], i=0..31.
//  - On every valid word: hist <= dataIn[6:0]; histValid <= 1. Gaps (valid=0) keep hist.
//  - First valid word after reset: loads hist only, not checked, no counter/state effect.
//  - Word is "bad" if m != 0 OR dataIn == 32'h0 (PRBS7 never has >6 consecutive zeros).
//    An all-zero word contributes 32 to the error sum.
//  - Pipeline:
//    - edge N samples the word; m, bad flag and popcount are registered at N.
//    - errFlag, errCnt, wordCnt, state and locked update at N+1 and are visible after N+1 (latency 2).
//  - FSM UNLOCKED:
//    - good word increments goodStreak; bad word zeroes it.
//    - goodStreak reaching LOCK_WORDS -> LOCKED; errCnt and wordCnt cleared on entry.
//  - FSM LOCKED:
//    - each checked word: wordCnt += 1; errCnt += popcount (32 for a zero word).
//    - bad word increments badStreak; good word zeroes it.
//    - badStreak reaching UNLOCK_WORDS -> UNLOCKED, goodStreak=0; errCnt and wordCnt freeze (hold) while UNLOCKED.
//  - errFlag pulses for any bad checked word in either state.
//  - Saturation: counters stick at all-ones, never wrap.
//  - clrErr sets errCnt=0 and wordCnt=0 next edge; it wins over a simultaneous increment. State is not affected.
//  - A single flipped bit yields 3 mismatches (positions i, i-6, i-7, possibly spanning into the next word).
//  - RSTn asserted mid-stream: immediate return to reset values; first word after release only reloads hist.
// CONFIGURATION
//  - PRBS7_CHK_ERRVEC_EN defined: adds output errVec[31:0], the registered m of the last checked word
//    (same timing as errFlag, 0 on reset, holds between words).
//  - Undefined: port absent; no extra flops.
// STRUCTURE
//  - Package prbs7_chk_pkg: state enum {ST_UNLOCKED, ST_LOCKED}, PRBS7_LEN=7, tap offsets TAP_A=6/TAP_B=7, word width 32.
//  - Sub-module prbs7_chk_popcnt32: combinational 32-bit popcount, 6-bit result.
//  - Mismatch, FSM and counters live in the top module.
// TESTING
//  - Clean lock: generator words (seed 7'h7F), valid every cycle -> locked rises 2 cycles after 9th valid word; errCnt=0.
//  - Single flip: while LOCKED, invert bit 20 of one word -> errFlag one pulse, errCnt += 3, locked stays 1.
//  - Cross-word: invert bit 2 of word k -> errCnt += 3 total; errFlag pulses for words k and k+1.
//  - Zero input: 12 words of 32'h0 after reset -> locked stays 0, errFlag pulses for each checked word.
//  - Unlock/hysteresis:
//    - 3 errored words then a clean word -> locked stays 1.
//    - 4 consecutive errored words -> locked falls; errCnt then holds.
//  - Saturation/clear (CNT_W=4): a zero word while LOCKED -> errCnt=15.
//    clrErr coincident with an error word -> errCnt=0.

Source files
------------

// File: rtl/prbs7_chk_pkg.sv
// Shared types and constants for the 32-bit PRBS7 receive checker.
package prbs7_chk_pkg;

    localparam int WORD_W    = 32;
    localparam int PRBS7_LEN = 7;
    localparam int TAP_A     = 6;
    localparam int TAP_B     = 7;
    localparam int POP_W     = 6;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // Per-bit recurrence violation for one word, given the last PRBS7_LEN bits of
    // the previous word. Bit 31 is the oldest bit, so older bits sit at higher indices.
    function automatic logic [WORD_W-1:0] prbs7_mismatch(
        input logic [PRBS7_LEN-1:0] hist,
        input logic [WORD_W-1:0]    data
    );
        logic [WORD_W+PRBS7_LEN-1:0] x;
        logic [WORD_W-1:0]           m;
        x = {hist, data};
        m = '0;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            m[i] = x[i] ^ x[i+TAP_A] ^ x[i+TAP_B];
        end
        return m;
    endfunction

endpackage

// File: rtl/prbs7_chk_popcnt32.sv
// Combinational population count of a 32-bit word (result 0..32).
module prbs7_chk_popcnt32
    import prbs7_chk_pkg::*;
(
    input  logic [WORD_W-1:0] i_data,
    output logic [POP_W-1:0]  o_count
);

    // Ripple sum of set bits.
    always_comb begin
        o_count = '0;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            o_count = o_count + POP_W'(i_data[i]);
        end
    end

endmodule

// File: rtl/prbs7_chk_32b.sv
// Self-synchronising 32-bit PRBS7 checker with lock FSM and saturating BER counters.
// Optional macro PRBS7_CHK_ERRVEC_EN adds the errVec[31:0] output (mismatch vector of
// the last checked word).
module prbs7_chk_32b
    import prbs7_chk_pkg::*;
#(
    parameter int LOCK_WORDS   = 8,
    parameter int UNLOCK_WORDS = 4,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [31:0]      dataIn,
    input  logic             dataInValid,
    input  logic             clrErr,
    output logic             locked,
    output logic             errFlag,
    output logic [CNT_W-1:0] errCnt,
    output logic [CNT_W-1:0] wordCnt
`ifdef PRBS7_CHK_ERRVEC_EN
    ,
    output logic [31:0]      errVec
`endif
);

    localparam int GS_W  = $clog2(LOCK_WORDS + 1);
    localparam int BS_W  = $clog2(UNLOCK_WORDS + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    // Stage 1: sampled word analysis
    logic [PRBS7_LEN-1:0] r_hist;
    logic                 r_histValid;
    logic                 r_chk;
    logic                 r_bad;
    logic [POP_W-1:0]     r_pop;

    logic [WORD_W-1:0]    w_m;
    logic                 w_zero;
    logic [POP_W-1:0]     w_pop;

    // Stage 2: FSM and counters
    state_t               r_state,   w_state_nxt;
    logic [GS_W-1:0]      r_gs,      w_gs_nxt;
    logic [BS_W-1:0]      r_bs,      w_bs_nxt;
    logic [CNT_W-1:0]     r_errCnt,  w_err_nxt;
    logic [CNT_W-1:0]     r_wordCnt, w_word_nxt;
    logic                 r_flag,    w_flag_nxt;

    logic [SUM_W-1:0]     w_err_sum;
    logic [CNT_W-1:0]     w_err_sat;
    logic [CNT_W-1:0]     w_word_sat;

    assign w_m    = prbs7_mismatch(r_hist, dataIn);
    assign w_zero = (dataIn == '0);

    prbs7_chk_popcnt32 u_popcnt (
        .i_data  (w_m),
        .o_count (w_pop)
    );

    // Capture history and per-word verdict; the first word after reset only seeds history.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_hist      <= '0;
            r_histValid <= 1'b0;
            r_chk       <= 1'b0;
            r_bad       <= 1'b0;
            r_pop       <= '0;
        end else begin
            r_chk <= dataInValid & r_histValid;
            if (dataInValid) begin
                r_hist      <= dataIn[PRBS7_LEN-1:0];
                r_histValid <= 1'b1;
                r_bad       <= (w_m != '0) | w_zero;
                // A zero word is charged a full word of errors regardless of m.
                r_pop       <= w_zero ? POP_W'(WORD_W) : w_pop;
            end
        end
    end

    assign w_err_sum  = SUM_W'(r_errCnt) + SUM_W'(r_pop);
    assign w_err_sat  = (w_err_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : w_err_sum[CNT_W-1:0];
    assign w_word_sat = (r_wordCnt == '1) ? r_wordCnt : r_wordCnt + 1'b1;

    // Lock FSM next state, streak tracking and saturating counter updates.
    always_comb begin
        w_state_nxt = r_state;
        w_gs_nxt    = r_gs;
        w_bs_nxt    = r_bs;
        w_err_nxt   = r_errCnt;
        w_word_nxt  = r_wordCnt;
        w_flag_nxt  = r_chk & r_bad;
        if (r_chk) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (r_bad) begin
                        w_gs_nxt = '0;
                    end else if (r_gs == GS_W'(LOCK_WORDS - 1)) begin
                        w_state_nxt = ST_LOCKED;
                        w_gs_nxt    = '0;
                        w_bs_nxt    = '0;
                        w_err_nxt   = '0;
                        w_word_nxt  = '0;
                    end else begin
                        w_gs_nxt = r_gs + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    w_word_nxt = w_word_sat;
                    w_err_nxt  = w_err_sat;
                    if (!r_bad) begin
                        w_bs_nxt = '0;
                    end else if (r_bs == BS_W'(UNLOCK_WORDS - 1)) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_gs_nxt    = '0;
                        w_bs_nxt    = '0;
                    end else begin
                        w_bs_nxt = r_bs + 1'b1;
                    end
                end
                default: w_state_nxt = ST_UNLOCKED;
            endcase
        end
        if (clrErr) begin
            w_err_nxt  = '0;
            w_word_nxt = '0;
        end
    end

    // FSM state, streaks, counters and error pulse registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state   <= ST_UNLOCKED;
            r_gs      <= '0;
            r_bs      <= '0;
            r_errCnt  <= '0;
            r_wordCnt <= '0;
            r_flag    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gs      <= w_gs_nxt;
            r_bs      <= w_bs_nxt;
            r_errCnt  <= w_err_nxt;
            r_wordCnt <= w_word_nxt;
            r_flag    <= w_flag_nxt;
        end
    end

    assign locked  = (r_state == ST_LOCKED);
    assign errFlag = r_flag;
    assign errCnt  = r_errCnt;
    assign wordCnt = r_wordCnt;

`ifdef PRBS7_CHK_ERRVEC_EN
    logic [WORD_W-1:0] r_m;
    logic [WORD_W-1:0] r_errVec;

    // Mismatch vector follows the same two-stage timing as errFlag and holds between words.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_m      <= '0;
            r_errVec <= '0;
        end else begin
            if (dataInValid) begin
                r_m <= w_m;
            end
            if (r_chk) begin
                r_errVec <= r_m;
            end
        end
    end

    assign errVec = r_errVec;
`endif

endmodule

// File: tb/tb_prbs7_chk_32b.sv
// Self-checking bench for prbs7_chk_32b: default instance plus a CNT_W=4 instance
// sharing the same stimulus, checked against a bit-serial reference model.
module tb_prbs7_chk_32b;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [31:0] dataIn = '0;
    logic        dataInValid = 1'b0;
    logic        clrErr = 1'b0;

    logic        locked, errFlag, locked4, errFlag4;
    logic [15:0] errCnt, wordCnt;
    logic [3:0]  errCnt4, wordCnt4;

    prbs7_chk_32b #(.LOCK_WORDS(8), .UNLOCK_WORDS(4), .CNT_W(16)) dut (
        .CLK(CLK), .RSTn(RSTn), .dataIn(dataIn), .dataInValid(dataInValid), .clrErr(clrErr),
        .locked(locked), .errFlag(errFlag), .errCnt(errCnt), .wordCnt(wordCnt)
    );

    prbs7_chk_32b #(.LOCK_WORDS(8), .UNLOCK_WORDS(4), .CNT_W(4)) dut4 (
        .CLK(CLK), .RSTn(RSTn), .dataIn(dataIn), .dataInValid(dataInValid), .clrErr(clrErr),
        .locked(locked4), .errFlag(errFlag4), .errCnt(errCnt4), .wordCnt(wordCnt4)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic lk;
        logic fl;
        int   ec;
        int   wc;
        int   ec4;
        int   wc4;
    } exp_t;

    typedef struct {
        logic [31:0] mask;
        int          d_err;
        int          pulses;
        string       name;
    } flip_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   flag_cnt = 0;

    // Reference model state
    logic [6:0] mh;
    logic       mhv, p_chk, p_bad, m_lk, m_fl;
    int         p_pop, gs, bs, m_ec, m_wc, m_ec4, m_wc4;
    logic [6:0] g;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic model_reset();
        mh = '0; mhv = 1'b0; p_chk = 1'b0; p_bad = 1'b0; p_pop = 0;
        m_lk = 1'b0; m_fl = 1'b0; gs = 0; bs = 0;
        m_ec = 0; m_wc = 0; m_ec4 = 0; m_wc4 = 0;
    endtask

    // One clock edge of expected behaviour: retire the pending word, then accept the new one.
    task automatic model_edge(input logic [31:0] d, input logic v, input logic c);
        int   pop;
        logic b;
        m_fl = p_chk && p_bad;
        if (p_chk) begin
            if (!m_lk) begin
                if (p_bad) gs = 0; else gs++;
                if (gs == 8) begin
                    m_lk = 1'b1; gs = 0; bs = 0;
                    m_ec = 0; m_wc = 0; m_ec4 = 0; m_wc4 = 0;
                end
            end else begin
                m_wc  = sat(m_wc + 1, 65535);
                m_ec  = sat(m_ec + p_pop, 65535);
                m_wc4 = sat(m_wc4 + 1, 15);
                m_ec4 = sat(m_ec4 + p_pop, 15);
                if (p_bad) bs++; else bs = 0;
                if (bs == 4) begin
                    m_lk = 1'b0; gs = 0; bs = 0;
                end
            end
        end
        if (c) begin
            m_ec = 0; m_wc = 0; m_ec4 = 0; m_wc4 = 0;
        end
        p_chk = v && mhv;
        if (v) begin
            pop = 0;
            for (int i = 31; i >= 0; i--) begin
                b = d[i];
                if (b ^ mh[6] ^ mh[5]) pop++;
                mh = {mh[5:0], b};
            end
            if (d == '0) pop = 32;
            p_pop = pop;
            p_bad = (pop != 0);
            mhv   = 1'b1;
        end
    endtask

    task automatic gen_word(output logic [31:0] w);
        logic nb;
        for (int i = 31; i >= 0; i--) begin
            nb   = g[6] ^ g[5];
            w[i] = nb;
            g    = {g[5:0], nb};
        end
    endtask

    // Drive one cycle from a negedge, queue the expectation, compare just after the edge.
    task automatic cycle(input logic [31:0] d, input logic v, input logic c);
        exp_t e;
        dataIn = d; dataInValid = v; clrErr = c;
        model_edge(d, v, c);
        sb_q.push_back('{m_lk, m_fl, m_ec, m_wc, m_ec4, m_wc4});
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        chk("sb_locked",   int'(locked),   int'(e.lk));
        chk("sb_errFlag",  int'(errFlag),  int'(e.fl));
        chk("sb_errCnt",   int'(errCnt),   e.ec);
        chk("sb_wordCnt",  int'(wordCnt),  e.wc);
        chk("sb_locked4",  int'(locked4),  int'(e.lk));
        chk("sb_errFlag4", int'(errFlag4), int'(e.fl));
        chk("sb_errCnt4",  int'(errCnt4),  e.ec4);
        chk("sb_wordCnt4", int'(wordCnt4), e.wc4);
        if (errFlag) flag_cnt++;
        @(negedge CLK);
    endtask

    task automatic good(input int n);
        logic [31:0] w;
        for (int k = 0; k < n; k++) begin
            gen_word(w);
            cycle(w, 1'b1, 1'b0);
        end
    endtask

    task automatic flip(input logic [31:0] mask);
        logic [31:0] w;
        gen_word(w);
        cycle(w ^ mask, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        flip_t       ft[6];
        logic [31:0] w;

        ft[0] = '{32'h0010_0000, 3, 1, "flip_b20"};
        ft[1] = '{32'h0000_0004, 3, 2, "flip_b2"};
        ft[2] = '{32'h0000_0040, 3, 2, "flip_b6"};
        ft[3] = '{32'h0000_0001, 3, 2, "flip_b0"};
        ft[4] = '{32'h8000_0000, 3, 1, "flip_b31"};
        ft[5] = '{32'h0010_4000, 4, 1, "flip_b20_b14"};

        model_reset();
        g = 7'h7F;

        // Reset values
        #3;
        chk("rst_locked",  int'(locked),  0);
        chk("rst_errFlag", int'(errFlag), 0);
        chk("rst_errCnt",  int'(errCnt),  0);
        chk("rst_wordCnt", int'(wordCnt), 0);
        @(negedge CLK);
        RSTn = 1'b1;

        // Clean lock: nine words, lock visible after the edge following the ninth
        good(9);
        chk("lock_early", int'(locked), 0);
        good(1);
        chk("lock_rise", int'(locked), 1);
        chk("lock_errCnt", int'(errCnt), 0);
        good(4);

        // Single and cross-word flips while locked
        for (int t = 0; t < 6; t++) begin
            gen_word(w);
            cycle(w, 1'b1, 1'b1);
            flag_cnt = 0;
            flip(ft[t].mask);
            good(3);
            chk({ft[t].name, "_errCnt"}, int'(errCnt), ft[t].d_err);
            chk({ft[t].name, "_pulses"}, flag_cnt, ft[t].pulses);
            chk({ft[t].name, "_locked"}, int'(locked), 1);
        end

        // Hysteresis: three errored words do not unlock, four do
        gen_word(w);
        cycle(w, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) flip(32'h0010_0000);
        good(3);
        chk("hyst3_locked", int'(locked), 1);
        for (int k = 0; k < 4; k++) flip(32'h0010_0000);
        good(1);
        chk("hyst4_locked", int'(locked), 0);
        chk("hyst4_errCnt", int'(errCnt), 21);
        chk("hyst4_errCnt4", int'(errCnt4), 15);
        for (int k = 0; k < 3; k++) flip(32'h0010_0000);
        good(3);
        chk("unlocked_hold", int'(errCnt), 21);

        // Relock with idle gaps between valid words
        for (int k = 0; k < 12; k++) begin
            gen_word(w);
            cycle(w, 1'b1, 1'b0);
            cycle($urandom, 1'b0, 1'b0);
        end
        chk("gap_relock", int'(locked), 1);
        chk("gap_errCnt", int'(errCnt), 0);

        // Saturation of the 4-bit counter, then clear winning over an increment
        cycle(32'h0, 1'b1, 1'b0);
        good(2);
        chk("zero_sat4", int'(errCnt4), 15);
        flip(32'h0010_0000);
        gen_word(w);
        cycle(w, 1'b1, 1'b1);
        chk("clr_win", int'(errCnt), 0);
        chk("clr_win4", int'(errCnt4), 0);
        good(2);

        // Asynchronous reset mid-cycle
        #2;
        RSTn = 1'b0;
        #1;
        chk("arst_locked",  int'(locked),  0);
        chk("arst_errCnt",  int'(errCnt),  0);
        chk("arst_wordCnt", int'(wordCnt), 0);
        model_reset();
        sb_q.delete();
        g = 7'h7F;
        @(negedge CLK);
        RSTn = 1'b1;

        // Zero input never locks; every checked word flags
        flag_cnt = 0;
        for (int k = 0; k < 12; k++) cycle(32'h0, 1'b1, 1'b0);
        cycle(32'h0, 1'b0, 1'b0);
        cycle(32'h0, 1'b0, 1'b0);
        chk("zero_locked", int'(locked), 0);
        chk("zero_pulses", flag_cnt, 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
